cache_stream_sequencer: RTL and testbench

CACHE_STREAM_SEQUENCER -- requirements
Module: cache_stream_sequencer

---
 rtl/cache_stream_sequencer.sv | 141 ++++++++++++++
 tb/tb_cache_stream_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_stream_sequencer.sv
// rtl/cache_stream_sequencer.sv - per-channel cache-line stream sequencer with round-robin dcache issue
module cache_stream_sequencer #(
    parameter int NUM_CH     = 2,
    parameter int DEPTH_W    = 8,
    parameter int LINE_BYTES = 64,
    parameter int MAX_OUT    = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req_valid,
    output logic [NUM_CH-1:0]         req_ready,
    input  logic [NUM_CH*32-1:0]      req_base,
    input  logic [NUM_CH*DEPTH_W-1:0] req_depth,
    output logic                      dc_req_valid,
    input  logic                      dc_req_ready,
    output logic [31:0]               dc_req_addr,
    output logic [CH_W-1:0]           dc_req_ch,
    input  logic                      dc_resp_valid,
    input  logic [CH_W-1:0]           dc_resp_ch,
    output logic                      pipeline_stall,
    output logic [NUM_CH-1:0]         done
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

    localparam logic [31:0] LINE_STEP = 32'(LINE_BYTES);
    localparam logic [31:0] LINE_MASK = ~(LINE_STEP - 32'd1);
    localparam logic [3:0]  OUT_LIMIT = 4'(MAX_OUT);

    state_t               st_q   [NUM_CH];
    state_t               st_d   [NUM_CH];
    logic [31:0]          addr_q [NUM_CH];
    logic [DEPTH_W-1:0]   rem_q  [NUM_CH];
    logic [3:0]           out_q  [NUM_CH];
    logic [3:0]           out_d  [NUM_CH];

    logic [NUM_CH-1:0]    accept, zero_depth, issue_hit, resp_hit, eligible, busy;
    logic [2*NUM_CH-1:0]  elig_rot;
    logic [CH_W:0]        grant_sum;
    logic [CH_W-1:0]      rr_ptr, grant_ch;
    logic                 grant_found, hs;

    assign hs = dc_req_valid & dc_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) st_q[i] <= S_IDLE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) st_q[i] <= st_d[i];
        end
    end

    // A same-cycle issue and response on one channel cancel; a response with nothing outstanding is dropped.
    always_comb begin
        accept     = '0;
        zero_depth = '0;
        issue_hit  = '0;
        resp_hit   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            accept[i]     = req_valid[i] && (st_q[i] == S_IDLE);
            zero_depth[i] = (req_depth[i*DEPTH_W +: DEPTH_W] == '0);
            issue_hit[i]  = hs && (dc_req_ch == CH_W'(i));
            resp_hit[i]   = dc_resp_valid && (dc_resp_ch == CH_W'(i));
            out_d[i] = out_q[i];
            if (issue_hit[i] && !resp_hit[i])
                out_d[i] = out_q[i] + 4'd1;
            else if (!issue_hit[i] && resp_hit[i] && (out_q[i] != 4'd0))
                out_d[i] = out_q[i] - 4'd1;
            st_d[i] = st_q[i];
            case (st_q[i])
                S_IDLE:  if (accept[i] && !zero_depth[i]) st_d[i] = S_ISSUE;
                S_ISSUE: if (issue_hit[i] && (rem_q[i] == DEPTH_W'(1))) st_d[i] = S_DRAIN;
                S_DRAIN: if (out_d[i] == 4'd0) st_d[i] = S_IDLE;
                default: st_d[i] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = '0;
        busy      = '0;
        eligible  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_ready[i] = (st_q[i] == S_IDLE);
            busy[i]      = (st_q[i] != S_IDLE);
            eligible[i]  = (st_q[i] == S_ISSUE) && (rem_q[i] != '0) && (out_q[i] < OUT_LIMIT);
        end
        elig_rot    = {eligible, eligible} >> rr_ptr;
        grant_found = 1'b0;
        grant_sum   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!grant_found && elig_rot[k]) begin
                grant_found = 1'b1;
                grant_sum   = {1'b0, rr_ptr} + (CH_W+1)'(k);
            end
        end
        grant_ch = (grant_sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(grant_sum - (CH_W+1)'(NUM_CH))
                                                    : grant_sum[CH_W-1:0];
    end

    // Arbitration only happens while no request is pending, so the granted address is never stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
                rem_q[i]  <= '0;
                out_q[i]  <= '0;
            end
            rr_ptr         <= '0;
            dc_req_valid   <= 1'b0;
            dc_req_addr    <= '0;
            dc_req_ch      <= '0;
            pipeline_stall <= 1'b0;
            done           <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                out_q[i] <= out_d[i];
                if (accept[i]) begin
                    addr_q[i] <= req_base[i*32 +: 32] & LINE_MASK;
                    rem_q[i]  <= req_depth[i*DEPTH_W +: DEPTH_W];
                end else if (issue_hit[i]) begin
                    addr_q[i] <= addr_q[i] + LINE_STEP;
                    rem_q[i]  <= rem_q[i] - DEPTH_W'(1);
                end
                done[i] <= (accept[i] && zero_depth[i]) ||
                           ((st_q[i] == S_DRAIN) && (st_d[i] == S_IDLE));
            end
            pipeline_stall <= |busy;
            if (hs) begin
                dc_req_valid <= 1'b0;
                rr_ptr       <= (dc_req_ch == CH_W'(NUM_CH-1)) ? '0 : dc_req_ch + CH_W'(1);
            end else if (!dc_req_valid && grant_found) begin
                dc_req_valid <= 1'b1;
                dc_req_addr  <= addr_q[grant_ch];
                dc_req_ch    <= grant_ch;
            end
        end
    end

endmodule

// File: tb/tb_cache_stream_sequencer.sv
// tb/tb_cache_stream_sequencer.sv - scoreboard bench for cache_stream_sequencer
module tb_cache_stream_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_base = '0;
    logic [15:0] req_depth = '0;
    logic        dc_req_valid;
    logic        dc_req_ready = 1'b1;
    logic [31:0] dc_req_addr;
    logic [0:0]  dc_req_ch;
    logic        dc_resp_valid = 1'b0;
    logic [0:0]  dc_resp_ch = '0;
    logic        pipeline_stall;
    logic [1:0]  done;

    cache_stream_sequencer #(.NUM_CH(2), .DEPTH_W(8), .LINE_BYTES(64), .MAX_OUT(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_base(req_base), .req_depth(req_depth), .dc_req_valid(dc_req_valid),
        .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr), .dc_req_ch(dc_req_ch),
        .dc_resp_valid(dc_resp_valid), .dc_resp_ch(dc_resp_ch),
        .pipeline_stall(pipeline_stall), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [0:0] ch; } resp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          done_cnt [2] = '{0, 0};
    logic [32:0] exp_q [$];
    resp_t       resp_q [$];
    bit          auto_resp = 1'b0;

    // One clock: drive scheduled response, score any handshake taking place at the coming edge.
    task automatic tick();
        resp_t       r;
        logic [32:0] e;
        dc_resp_valid = 1'b0;
        dc_resp_ch    = '0;
        if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            r = resp_q.pop_front();
            dc_resp_valid = 1'b1;
            dc_resp_ch    = r.ch;
        end
        if (!reset && dc_req_valid && dc_req_ready) begin
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got ch=%0d addr=%h, expected no request", dc_req_ch, dc_req_addr);
            end else begin
                e = exp_q.pop_front();
                if ({dc_req_ch, dc_req_addr} !== e) begin
                    bad++;
                    $display("FAIL issue_order: got ch=%0d addr=%h, want ch=%0d addr=%h",
                             dc_req_ch, dc_req_addr, e[32], e[31:0]);
                end
            end
            if (auto_resp) resp_q.push_back('{cyc + 2, dc_req_ch});
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) if (done[i] === 1'b1) done_cnt[i]++;
    endtask

    task automatic run_until_done(input int ch, input int d0, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit && !ok; n++) begin
            tick();
            if (done_cnt[ch] != d0) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        exp_q.delete();
        resp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        #2;
        total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dc_req_valid); end
        total++; if (dc_req_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", dc_req_addr); end
        total++; if (dc_req_ch !== 1'b0) begin bad++; $display("FAIL reset_ch: got %0d want 0", dc_req_ch); end
        total++; if (pipeline_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", pipeline_stall); end
        total++; if (done !== 2'b00) begin bad++; $display("FAIL reset_done: got %b want 00", done); end
        tick();
        reset = 1'b0;
        tick();
        total++; if (req_ready !== 2'b11) begin bad++; $display("FAIL reset_ready: got %b want 11", req_ready); end
    endtask

    task automatic test_single_stream();
        int d0 = done_cnt[0];
        int h0 = hs_cnt;
        bit ok;
        auto_resp = 1'b1;
        dc_req_ready = 1'b1;
        req_base[31:0] = 32'h0000_1010;
        req_depth[7:0] = 8'd3;
        exp_q.push_back({1'b0, 32'h0000_1000});
        exp_q.push_back({1'b0, 32'h0000_1040});
        exp_q.push_back({1'b0, 32'h0000_1080});
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        total++; if (pipeline_stall !== 1'b1) begin bad++; $display("FAIL single_stall_on: got %b want 1", pipeline_stall); end
        run_until_done(0, d0, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_done: got no done pulse, want one within 60 cycles"); end
        total++; if (pipeline_stall !== 1'b1) begin bad++; $display("FAIL single_stall_at_done: got %b want 1", pipeline_stall); end
        tick();
        total++; if (pipeline_stall !== 1'b0) begin bad++; $display("FAIL single_stall_off: got %b want 0", pipeline_stall); end
        total++; if (done[0] !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b want 0", done[0]); end
        repeat (3) tick();
        total++; if (hs_cnt - h0 != 3) begin bad++; $display("FAIL single_issues: got %0d want 3", hs_cnt - h0); end
        total++; if (done_cnt[0] - d0 != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt[0] - d0); end
    endtask

    task automatic test_credit_limit();
        int d0 = done_cnt[0];
        int h0 = hs_cnt;
        bit ok;
        auto_resp = 1'b0;
        req_base[31:0] = 32'h0000_0000;
        req_depth[7:0] = 8'd6;
        for (int k = 0; k < 6; k++) exp_q.push_back({1'b0, 32'(k * 64)});
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        repeat (25) tick();
        total++; if (hs_cnt - h0 != 4) begin bad++; $display("FAIL credit_issues: got %0d want 4", hs_cnt - h0); end
        total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL credit_valid: got %b want 0", dc_req_valid); end
        for (int k = 0; k < 4; k++) resp_q.push_back('{cyc + k, 1'b0});
        auto_resp = 1'b1;
        run_until_done(0, d0, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL credit_done: got no done pulse, want one within 100 cycles"); end
        total++; if (hs_cnt - h0 != 6) begin bad++; $display("FAIL credit_total: got %0d want 6", hs_cnt - h0); end
    endtask

    task automatic test_round_robin();
        int  d0, d1;
        bit  ok;
        do_reset();
        d0 = done_cnt[0];
        d1 = done_cnt[1];
        auto_resp = 1'b1;
        req_base  = {32'h0000_8000, 32'h0000_2000};
        req_depth = {8'd2, 8'd2};
        exp_q.push_back({1'b0, 32'h0000_2000});
        exp_q.push_back({1'b1, 32'h0000_8000});
        exp_q.push_back({1'b0, 32'h0000_2040});
        exp_q.push_back({1'b1, 32'h0000_8040});
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        ok = 1'b0;
        for (int n = 0; n < 80 && !ok; n++) begin
            tick();
            ok = (done_cnt[0] != d0) && (done_cnt[1] != d1);
        end
        total++; if (!ok) begin bad++; $display("FAIL rr_done: got done0=%0d done1=%0d, want both", done_cnt[0] - d0, done_cnt[1] - d1); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_leftover: got %0d pending, want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int          d1 = done_cnt[1];
        int          h0;
        bit          ok;
        logic [31:0] a;
        logic [0:0]  c;
        dc_req_ready = 1'b0;
        req_base[63:32] = 32'h0000_3004;
        req_depth[15:8] = 8'd1;
        exp_q.push_back({1'b1, 32'h0000_3000});
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        for (int n = 0; n < 10 && dc_req_valid !== 1'b1; n++) tick();
        total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", dc_req_valid); end
        a = dc_req_addr;
        c = dc_req_ch;
        for (int n = 0; n < 5; n++) begin
            tick();
            total++;
            if (dc_req_valid !== 1'b1 || dc_req_addr !== a || dc_req_ch !== c) begin
                bad++;
                $display("FAIL bp_hold: got v=%b addr=%h ch=%0d want v=1 addr=%h ch=%0d",
                         dc_req_valid, dc_req_addr, dc_req_ch, a, c);
            end
        end
        h0 = hs_cnt;
        dc_req_ready = 1'b1;
        repeat (5) tick();
        total++; if (hs_cnt - h0 != 1) begin bad++; $display("FAIL bp_single: got %0d handshakes want 1", hs_cnt - h0); end
        run_until_done(1, d1, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_done: got no done pulse on ch1, want one"); end
    endtask

    task automatic test_edges();
        int d0 = done_cnt[0];
        int h0 = hs_cnt;
        bit ok;
        req_base[31:0] = 32'h0000_7000;
        req_depth[7:0] = 8'd0;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        total++; if (done[0] !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done[0]); end
        repeat (4) tick();
        total++; if (hs_cnt != h0) begin bad++; $display("FAIL zero_issue: got %0d handshakes want 0", hs_cnt - h0); end
        total++; if (done_cnt[0] - d0 != 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_cnt[0] - d0); end
        total++; if (pipeline_stall !== 1'b0) begin bad++; $display("FAIL zero_stall: got %b want 0", pipeline_stall); end
        d0 = done_cnt[0];
        req_base[31:0] = 32'hFFFF_FFC0;
        req_depth[7:0] = 8'd2;
        exp_q.push_back({1'b0, 32'hFFFF_FFC0});
        exp_q.push_back({1'b0, 32'h0000_0000});
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        run_until_done(0, d0, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_done: got no done pulse, want one"); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_leftover: got %0d pending, want 0", exp_q.size()); end
    endtask

    task automatic test_reset_drain();
        int d0 = done_cnt[0];
        int h0 = hs_cnt;
        bit ok;
        auto_resp = 1'b0;
        req_base[31:0] = 32'h0000_4000;
        req_depth[7:0] = 8'd2;
        exp_q.push_back({1'b0, 32'h0000_4000});
        exp_q.push_back({1'b0, 32'h0000_4040});
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        for (int n = 0; n < 20 && hs_cnt - h0 < 2; n++) tick();
        tick();
        total++; if (hs_cnt - h0 != 2) begin bad++; $display("FAIL drain_issues: got %0d want 2", hs_cnt - h0); end
        reset = 1'b1;
        #1;
        total++; if (dc_req_valid !== 1'b0 || pipeline_stall !== 1'b0 || done !== 2'b00 || req_ready !== 2'b11) begin
            bad++;
            $display("FAIL drain_reset: got v=%b stall=%b done=%b ready=%b want 0 0 00 11",
                     dc_req_valid, pipeline_stall, done, req_ready);
        end
        tick();
        tick();
        reset = 1'b0;
        resp_q.push_back('{cyc, 1'b0});
        resp_q.push_back('{cyc + 1, 1'b0});
        repeat (5) tick();
        total++; if (done_cnt[0] != d0) begin bad++; $display("FAIL drain_no_done: got %0d pulses want 0", done_cnt[0] - d0); end
        total++; if (pipeline_stall !== 1'b0 || req_ready !== 2'b11 || dc_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle: got stall=%b ready=%b v=%b want 0 11 0", pipeline_stall, req_ready, dc_req_valid);
        end
        auto_resp = 1'b1;
        req_base[31:0] = 32'h0000_5000;
        req_depth[7:0] = 8'd1;
        exp_q.push_back({1'b0, 32'h0000_5000});
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        run_until_done(0, d0, 40, ok);
        total++; if (!ok) begin bad++; $display("FAIL drain_restart: got no done pulse, want one"); end
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_credit_limit();
        test_round_robin();
        test_backpressure();
        test_edges();
        test_reset_drain();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL final_leftover: got %0d pending, want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
